// File: rtl/mlp_load_sequencer.sv
// Streams the 8-layer MLP load sequence (1152 beats) from a 1-cycle operand SRAM; MLP_LOAD_CHKSUM_EN adds an XOR checksum.
// Latency: start at edge E0 -> first beat after E2; beats are back-to-back, done_o one cycle after the last beat.
// Backpressure: none, the stream is free-running once started; abort_i is the only way to stop a job early.
module mlp_load_sequencer #(
  parameter int ADDR_W = 11,
  parameter int ROWS   = 16,
  parameter int BEATS  = 8,
  parameter int LAYERS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              load_en_o,
  output logic              load_type_o,
  output logic [31:0]       load_payload_o,
  output logic [3:0]        input_load_number_o,
  output logic [2:0]        layer_number_o,
  output logic [2:0]        weight_number_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       chksum_o
);

  typedef enum logic [2:0] {IDLE, L0_IN, L0_W, LN_W, FLUSH} state_t;

  state_t      state, state_n;
  logic [3:0]  row, row_n;
  logic [2:0]  beat, beat_n;
  logic [2:0]  layer, layer_n;
  logic        rd_en, rd_type, last_issue;
  logic        beat_end, row_end, layer_end;
  logic        accept, kill;
  logic [ADDR_W-1:0] in_addr, w_addr;

  // Read-stage tags, aligned with mem_rdata_i
  logic        s1_vld, s1_type, s1_last;
  logic [3:0]  s1_row;
  logic [2:0]  s1_layer, s1_beat;
  logic        o_last;

  assign beat_end  = (beat  == 3'(BEATS - 1));
  assign row_end   = (row   == 4'(ROWS - 1));
  assign layer_end = (layer == 3'(LAYERS - 1));

  assign busy_o = (state != IDLE) | s1_vld | load_en_o;
  assign accept = start_i & ~abort_i & ~busy_o & ~done_o;
  assign kill   = abort_i & busy_o;

  assign in_addr = ADDR_W'(row) * ADDR_W'(BEATS) + ADDR_W'(beat);
  assign w_addr  = ADDR_W'(ROWS * BEATS) + ADDR_W'(layer) * ADDR_W'(ROWS * BEATS) + in_addr;

  assign mem_rd_en_o = rd_en;
  assign mem_addr_o  = !rd_en ? '0 : (rd_type ? in_addr : w_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      beat  <= '0;
      layer <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      beat  <= beat_n;
      layer <= layer_n;
    end
  end

  always_comb begin
    state_n    = state;
    row_n      = row;
    beat_n     = beat;
    layer_n    = layer;
    rd_en      = 1'b0;
    rd_type    = 1'b0;
    last_issue = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = L0_IN;
          row_n   = '0;
          beat_n  = '0;
          layer_n = '0;
        end
      end
      L0_IN: begin
        rd_en   = 1'b1;
        rd_type = 1'b1;
        beat_n  = beat_end ? 3'd0 : beat + 3'd1;
        if (beat_end) state_n = L0_W;
      end
      L0_W: begin
        rd_en  = 1'b1;
        beat_n = beat_end ? 3'd0 : beat + 3'd1;
        if (beat_end) begin
          if (row_end) begin
            state_n = LN_W;
            row_n   = '0;
            layer_n = 3'd1;
          end else begin
            state_n = L0_IN;
            row_n   = row + 4'd1;
          end
        end
      end
      LN_W: begin
        rd_en  = 1'b1;
        beat_n = beat_end ? 3'd0 : beat + 3'd1;
        if (beat_end) begin
          row_n = row_end ? 4'd0 : row + 4'd1;
          if (row_end) begin
            // Layer counter parks at the last layer; the next accepted start clears it
            if (layer_end) begin
              state_n    = FLUSH;
              last_issue = 1'b1;
            end else begin
              layer_n = layer + 3'd1;
            end
          end
        end
      end
      FLUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (kill) begin
      state_n = IDLE;
      row_n   = '0;
      beat_n  = '0;
      layer_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      s1_vld   <= 1'b0;
      s1_type  <= 1'b0;
      s1_last  <= 1'b0;
      s1_row   <= '0;
      s1_layer <= '0;
      s1_beat  <= '0;
    end else begin
      s1_vld   <= rd_en;
      s1_type  <= rd_type;
      s1_last  <= last_issue;
      s1_row   <= row;
      s1_layer <= layer;
      s1_beat  <= rd_type ? 3'd0 : beat;
    end
  end

  // Output stage: idle cycles force every load_* field to zero
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      load_en_o           <= 1'b0;
      load_type_o         <= 1'b0;
      load_payload_o      <= '0;
      input_load_number_o <= '0;
      layer_number_o      <= '0;
      weight_number_o     <= '0;
      o_last              <= 1'b0;
      done_o              <= 1'b0;
    end else begin
      load_en_o           <= s1_vld;
      load_type_o         <= s1_vld & s1_type;
      load_payload_o      <= s1_vld ? mem_rdata_i : 32'd0;
      input_load_number_o <= s1_vld ? s1_row : 4'd0;
      layer_number_o      <= s1_vld ? s1_layer : 3'd0;
      weight_number_o     <= s1_vld ? s1_beat : 3'd0;
      o_last              <= s1_vld & s1_last;
      done_o              <= o_last;
    end
  end

`ifdef MLP_LOAD_CHKSUM_EN
  logic [31:0] chk;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      chk <= '0;
    end else if (s1_vld && !kill) begin
      chk <= chk ^ mem_rdata_i;
    end
  end

  assign chksum_o = chk;
`else
  assign chksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Self-checking bench for mlp_load_sequencer: SRAM model, beat-index reference model, vector table and corner sequences.
module tb_mlp_load_sequencer;

  logic        clk = 1'b0;
  logic        rst, start_i, abort_i;
  logic        mem_rd_en_o;
  logic [10:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic        load_en_o, load_type_o;
  logic [31:0] load_payload_o;
  logic [3:0]  input_load_number_o;
  logic [2:0]  layer_number_o, weight_number_o;
  logic        busy_o, done_o;
  logic [31:0] chksum_o;

  always #5 clk = ~clk;

  mlp_load_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .load_en_o(load_en_o), .load_type_o(load_type_o), .load_payload_o(load_payload_o),
    .input_load_number_o(input_load_number_o), .layer_number_o(layer_number_o),
    .weight_number_o(weight_number_o), .busy_o(busy_o), .done_o(done_o), .chksum_o(chksum_o)
  );

  logic [31:0] mem [0:2047];
  always @(posedge clk) if (mem_rd_en_o) mem_rdata_i <= mem[mem_addr_o];

  int checks = 0;
  int failures = 0;
  logic [42:0] cap [0:1151];

  typedef struct {
    int          beat;
    logic        typ;
    logic [3:0]  row;
    logic [2:0]  layer;
    logic [2:0]  wn;
    logic [31:0] pay;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Beat n -> (address, tags) straight from the address map and the job ordering
  function automatic void model(input int n, output logic [10:0] addr, output logic typ,
                                output logic [3:0] row, output logic [2:0] layer, output logic [2:0] wn);
    int m;
    if (n < 256) begin
      m     = n % 16;
      row   = 4'(n / 16);
      layer = 3'd0;
      if (m < 8) begin
        typ  = 1'b1;
        wn   = 3'd0;
        addr = 11'((n / 16) * 8 + m);
      end else begin
        typ  = 1'b0;
        wn   = 3'(m - 8);
        addr = 11'(128 + (n / 16) * 8 + (m - 8));
      end
    end else begin
      m     = n - 256;
      typ   = 1'b0;
      layer = 3'(1 + m / 128);
      row   = 4'((m % 128) / 8);
      wn    = 3'(m % 8);
      addr  = 11'(128 + (1 + m / 128) * 128 + (m % 128));
    end
  endfunction

  task automatic check_all_zero(input string name);
    check(name, {load_en_o, load_type_o, load_payload_o, input_load_number_o, layer_number_o,
                 weight_number_o, busy_o, done_o, mem_rd_en_o, mem_addr_o, chksum_o}, '0);
  endtask

  task automatic run_job(input int abort_cyc, input int rst_beat, input int sp_a, input int sp_b, input bit sp_done);
    logic [10:0] addr;
    logic        typ;
    logic [3:0]  row;
    logic [2:0]  layer, wn;
    logic [31:0] acc;
    logic        seen;
    int          cyc;
    acc = '0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check("issue0", {mem_rd_en_o, mem_addr_o, load_en_o, busy_o}, {1'b1, 11'd0, 1'b0, 1'b1});
    @(negedge clk);
    check("lat1", {mem_rd_en_o, mem_addr_o, load_en_o}, {1'b1, 11'd1, 1'b0});
    cyc = 2;
    if (abort_cyc >= 0) begin
      while (cyc < abort_cyc) begin
        @(negedge clk);
        cyc++;
      end
      abort_i = 1'b1;
      @(negedge clk); abort_i = 1'b0;
      check("abort_out", {load_en_o, busy_o, done_o, load_payload_o, mem_rd_en_o}, '0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        seen |= done_o | busy_o | load_en_o;
      end
      check("abort_quiet", seen, 1'b0);
      return;
    end
    @(negedge clk);
    for (int n = 0; n < 1152; n++) begin
      start_i = 1'b0;
      model(n, addr, typ, row, layer, wn);
      check($sformatf("beat%0d", n),
            {load_en_o, load_type_o, input_load_number_o, layer_number_o, weight_number_o, load_payload_o},
            {1'b1, typ, row, layer, wn, mem[addr]});
      cap[n] = {load_type_o, input_load_number_o, layer_number_o, weight_number_o, load_payload_o};
      acc ^= mem[addr];
      if (n == rst_beat) begin
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_all_zero("rst_mid");
        return;
      end
      if (n == sp_a || n == sp_b) start_i = 1'b1;
      @(negedge clk);
    end
    start_i = 1'b0;
    check("done_cycle", {done_o, busy_o, load_en_o, load_type_o, weight_number_o, load_payload_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0});
`ifdef MLP_LOAD_CHKSUM_EN
    check("chksum", chksum_o, acc);
`else
    check("chksum_off", chksum_o, 32'h0);
`endif
    if (sp_done) start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    check("done_once", {done_o, busy_o}, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= busy_o | load_en_o | mem_rd_en_o;
    end
    check("idle_after", seen, 1'b0);
  endtask

  initial begin
    tbl[0] = '{0,    1'b1, 4'd0,  3'd0, 3'd0, 32'd0};
    tbl[1] = '{7,    1'b1, 4'd0,  3'd0, 3'd0, 32'd7};
    tbl[2] = '{8,    1'b0, 4'd0,  3'd0, 3'd0, 32'd128};
    tbl[3] = '{15,   1'b0, 4'd0,  3'd0, 3'd7, 32'd135};
    tbl[4] = '{16,   1'b1, 4'd1,  3'd0, 3'd0, 32'd8};
    tbl[5] = '{255,  1'b0, 4'd15, 3'd0, 3'd7, 32'd255};
    tbl[6] = '{256,  1'b0, 4'd0,  3'd1, 3'd0, 32'd256};
    tbl[7] = '{383,  1'b0, 4'd15, 3'd1, 3'd7, 32'd383};
    tbl[8] = '{384,  1'b0, 4'd0,  3'd2, 3'd0, 32'd384};
    tbl[9] = '{1151, 1'b0, 4'd15, 3'd7, 3'd7, 32'd1151};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    for (int a = 0; a < 2048; a++) mem[a] = 32'(a);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_job(-1, -1, -1, -1, 1'b0);
    for (int i = 0; i < 10; i++)
      check($sformatf("vec_beat%0d", tbl[i].beat), cap[tbl[i].beat],
            {tbl[i].typ, tbl[i].row, tbl[i].layer, tbl[i].wn, tbl[i].pay});

    run_job(40, -1, -1, -1, 1'b0);
    @(negedge clk); abort_i = 1'b1; start_i = 1'b1;
    @(negedge clk); abort_i = 1'b0; start_i = 1'b0;
    check("abort_start_idle", {busy_o, mem_rd_en_o}, 2'b00);
    run_job(-1, -1, -1, -1, 1'b0);

    run_job(-1, -1, 10, 700, 1'b1);
    run_job(-1, 500, -1, -1, 1'b0);
    run_job(-1, -1, -1, -1, 1'b0);

    for (int a = 0; a < 2048; a++) mem[a] = 32'(a) * 32'h9E3779B9;
    run_job(-1, -1, -1, -1, 1'b0);

    for (int a = 0; a < 2048; a++) mem[a] = $urandom;
    run_job(int'($urandom_range(1100, 3)), -1, -1, -1, 1'b0);
    run_job(-1, -1, int'($urandom_range(1151, 0)), int'($urandom_range(1151, 0)), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
